// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, the IF/ID record and the
// reset/bubble constants used by the fetch stage.
package pipeline_pkg;

    localparam int               XLEN              = 32;
    localparam logic [XLEN-1:0]  TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [XLEN-1:0]  NOP_INSTR         = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    function automatic ifid_t bubble_ifid();
        ifid_t b;
        b.instruction = NOP_INSTR;
        b.pc_plus4    = '0;
        b.valid       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls and ROM data in, PC and IF/ID
// register contents out. The fetch unit is the slave side.
interface instruction_fetch_unit_if
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
);
    logic                  Stall_i;
    logic                  Flush_i;
    logic                  Redirect_i;
    logic [DATA_WIDTH-1:0] Redirect_Target_i;
    logic [DATA_WIDTH-1:0] Instruction_i;
    logic [DATA_WIDTH-1:0] Address_o;
    logic [DATA_WIDTH-1:0] IF_Instruction_o;
    logic [DATA_WIDTH-1:0] IF_PC_Plus4_o;
    logic                  IF_Valid_o;
    logic                  Fault_o;
    logic [DATA_WIDTH-1:0] Fault_Addr_o;

    modport master (
        output Stall_i, Flush_i, Redirect_i, Redirect_Target_i, Instruction_i,
        input  Address_o, IF_Instruction_o, IF_PC_Plus4_o, IF_Valid_o,
               Fault_o, Fault_Addr_o
    );

    modport slave (
        input  Stall_i, Flush_i, Redirect_i, Redirect_Target_i, Instruction_i,
        output Address_o, IF_Instruction_o, IF_PC_Plus4_o, IF_Valid_o,
               Fault_o, Fault_Addr_o
    );
endinterface

// File: rtl/fetch_window_check.sv
// Combinational text-window test: an address is legal when word aligned and
// inside [TEXT_BASE, TEXT_BASE + 4*MEMORY_DEPTH).
module fetch_window_check #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
    input  logic [DATA_WIDTH-1:0] addr,
    output logic                  legal
);
    // One extra bit so a window ending at the top of the address space cannot wrap.
    localparam logic [DATA_WIDTH:0] base_ext  = {1'b0, TEXT_BASE};
    localparam logic [DATA_WIDTH:0] limit_ext = base_ext + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    logic [DATA_WIDTH:0] addr_ext;

    assign addr_ext = {1'b0, addr};
    assign legal    = (addr[1:0] == 2'b00) && (addr_ext >= base_ext) && (addr_ext < limit_ext);

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, BOOT/RUN/FAULT control and the IF/ID
// pipeline register feeding decode.
module instruction_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = XLEN,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.slave  bus
);
    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] fault_addr_q, fault_addr_d;
    ifid_t                 ifid_q, ifid_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  target_legal;
    logic                  next_legal;

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    fetch_window_check #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .TEXT_BASE    (TEXT_BASE)
    ) u_target_check (
        .addr  (bus.Redirect_Target_i),
        .legal (target_legal)
    );

    fetch_window_check #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .TEXT_BASE    (TEXT_BASE)
    ) u_next_check (
        .addr  (pc_plus4),
        .legal (next_legal)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= TEXT_BASE;
            fault_addr_q <= '0;
            ifid_q       <= bubble_ifid();
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_addr_q <= fault_addr_d;
            ifid_q       <= ifid_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default up front; a path that
        // skipped one would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        ifid_d       = ifid_q;

        case (state_q)
            BOOT: begin
                ifid_d  = bubble_ifid();
                state_d = RUN;
            end

            RUN: begin
                if (bus.Redirect_i) begin
                    ifid_d = bubble_ifid();
                    if (target_legal) begin
                        pc_d = bus.Redirect_Target_i;
                    end else begin
                        state_d      = FAULT;
                        fault_addr_d = bus.Redirect_Target_i;
                    end
                end else if (bus.Flush_i) begin
                    ifid_d = bubble_ifid();
                    if (next_legal) begin
                        pc_d = pc_plus4;
                    end else begin
                        state_d      = FAULT;
                        fault_addr_d = pc_plus4;
                    end
                end else if (!bus.Stall_i) begin
                    // The current PC is always legal, so its instruction is kept
                    // even when the following address falls off the window.
                    ifid_d.instruction = bus.Instruction_i;
                    ifid_d.pc_plus4    = pc_plus4;
                    ifid_d.valid       = 1'b1;
                    if (next_legal) begin
                        pc_d = pc_plus4;
                    end else begin
                        state_d      = FAULT;
                        fault_addr_d = pc_plus4;
                    end
                end
            end

            FAULT: begin
                ifid_d = bubble_ifid();
            end

            default: begin
                state_d = FAULT;
                ifid_d  = bubble_ifid();
            end
        endcase
    end

    assign bus.Address_o        = pc_q;
    assign bus.IF_Instruction_o = ifid_q.instruction;
    assign bus.IF_PC_Plus4_o    = ifid_q.pc_plus4;
    assign bus.IF_Valid_o       = ifid_q.valid;
    assign bus.Fault_o          = (state_q == FAULT);
    assign bus.Fault_Addr_o     = fault_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; the ROM returns A000_0000 + word index.
module tb_instruction_fetch_unit;
    import pipeline_pkg::*;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    instruction_fetch_unit #(
        .MEMORY_DEPTH (64),
        .DATA_WIDTH   (32),
        .TEXT_BASE    (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.Instruction_i = 32'hA000_0000 + ((bus.Address_o - BASE) >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " addr"},  bus.Address_o,        BASE);
        check({tag, " instr"}, 32'(bus.IF_Instruction_o), 32'h0);
        check({tag, " pc4"},   bus.IF_PC_Plus4_o,    32'h0);
        check({tag, " valid"}, 32'(bus.IF_Valid_o),  32'h0);
        check({tag, " fault"}, 32'(bus.Fault_o),     32'h0);
        check({tag, " faddr"}, bus.Fault_Addr_o,     32'h0);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, " instr"}, bus.IF_Instruction_o, instr);
        check({tag, " pc4"},   bus.IF_PC_Plus4_o,    pc4);
        check({tag, " valid"}, 32'(bus.IF_Valid_o),  32'(valid));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.Stall_i           = 1'b0;
        bus.Flush_i           = 1'b0;
        bus.Redirect_i        = 1'b0;
        bus.Redirect_Target_i = 32'h0;

        // Power-on reset and first fetches
        step();
        check_reset_values("por");
        release_reset();
        step();
        check_ifid("boot", 32'h0, 32'h0, 1'b0);
        check("boot addr", bus.Address_o, BASE);
        step();
        check_ifid("w0", 32'hA000_0000, 32'h0040_0004, 1'b1);
        check("w0 addr", bus.Address_o, 32'h0040_0004);
        step();
        check_ifid("w1", 32'hA000_0001, 32'h0040_0008, 1'b1);
        check("w1 addr", bus.Address_o, 32'h0040_0008);

        // Three-cycle stall at PC 0040_0008
        bus.Stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("stall", 32'hA000_0001, 32'h0040_0008, 1'b1);
            check("stall addr", bus.Address_o, 32'h0040_0008);
        end
        bus.Stall_i = 1'b0;
        step();
        check_ifid("w2", 32'hA000_0002, 32'h0040_000C, 1'b1);
        check("w2 addr", bus.Address_o, 32'h0040_000C);

        // Redirect wins over a simultaneous stall
        bus.Redirect_i        = 1'b1;
        bus.Redirect_Target_i = 32'h0040_0020;
        bus.Stall_i           = 1'b1;
        step();
        check_ifid("redir bubble", 32'h0, 32'h0, 1'b0);
        check("redir addr", bus.Address_o, 32'h0040_0020);
        bus.Redirect_i = 1'b0;
        bus.Stall_i    = 1'b0;
        step();
        check_ifid("w8", 32'hA000_0008, 32'h0040_0024, 1'b1);

        // Flush inserts a bubble but the PC still advances
        bus.Flush_i = 1'b1;
        step();
        check_ifid("flush", 32'h0, 32'h0, 1'b0);
        check("flush addr", bus.Address_o, 32'h0040_0028);
        bus.Flush_i = 1'b0;
        step();
        check_ifid("w10", 32'hA000_000A, 32'h0040_002C, 1'b1);

        // Misaligned redirect target faults
        bus.Redirect_i        = 1'b1;
        bus.Redirect_Target_i = 32'h0040_0022;
        step();
        bus.Redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mis fault", 32'(bus.Fault_o), 32'h1);
            check("mis faddr", bus.Fault_Addr_o, 32'h0040_0022);
            check("mis valid", 32'(bus.IF_Valid_o), 32'h0);
            check("mis addr", bus.Address_o, 32'h0040_002C);
            step();
        end

        // Asynchronous reset while in FAULT
        reset = 1'b1;
        #1;
        check_reset_values("rst fault");
        release_reset();
        step();
        check_ifid("boot2", 32'h0, 32'h0, 1'b0);
        step();
        check_ifid("w0 again", 32'hA000_0000, 32'h0040_0004, 1'b1);

        // Redirect past the last ROM word faults
        bus.Redirect_i        = 1'b1;
        bus.Redirect_Target_i = 32'h0040_0100;
        step();
        bus.Redirect_i = 1'b0;
        check("oor fault", 32'(bus.Fault_o), 32'h1);
        check("oor faddr", bus.Fault_Addr_o, 32'h0040_0100);
        check("oor valid", 32'(bus.IF_Valid_o), 32'h0);
        check("oor addr", bus.Address_o, 32'h0040_0004);
        step();
        check("oor fault held", 32'(bus.Fault_o), 32'h1);
        check("oor valid held", 32'(bus.IF_Valid_o), 32'h0);

        // Asynchronous reset while running with a valid instruction in IF/ID
        reset = 1'b1;
        #1;
        check_reset_values("rst fault2");
        release_reset();
        step();
        step();
        check_ifid("pre run rst", 32'hA000_0000, 32'h0040_0004, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_values("rst run");
        release_reset();
        step();
        check_ifid("boot3", 32'h0, 32'h0, 1'b0);

        // Sequential run through the whole ROM, falling off the end
        for (int k = 0; k < 64; k++) begin
            step();
            check("seq instr", bus.IF_Instruction_o, 32'hA000_0000 + 32'(k));
            check("seq valid", 32'(bus.IF_Valid_o), 32'h1);
        end
        check("end pc4", bus.IF_PC_Plus4_o, 32'h0040_0100);
        check("end fault", 32'(bus.Fault_o), 32'h1);
        check("end faddr", bus.Fault_Addr_o, 32'h0040_0100);
        check("end addr", bus.Address_o, 32'h0040_00FC);
        step();
        check_ifid("end bubble", 32'h0, 32'h0, 1'b0);
        check("end fault held", 32'(bus.Fault_o), 32'h1);
        check("end addr held", bus.Address_o, 32'h0040_00FC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage that drives the word address into the instruction ROM and captures the returned instruction. It owns the program counter, sequential and redirected PC update, stall/flush handling and the IF/ID pipeline register. A text-window fault check stops fetch on an illegal PC. It sits between the program memory and the decode stage of the MIPS pipeline.

## Interface
- MEMORY_DEPTH, 64, number of 32-bit words in the instruction ROM
- DATA_WIDTH, 32, address and instruction width
- TEXT_BASE, 32'h0040_0000, byte address of ROM word 0
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Stall_i  input  1  hold PC and IF/ID register (hazard unit)
- Flush_i  input  1  replace next IF/ID contents with a bubble
- Redirect_i  input  1  load PC from Redirect_Target_i (taken branch/jump)
- Redirect_Target_i  input  DATA_WIDTH  byte target address
- Instruction_i  input  DATA_WIDTH  combinational ROM data for Address_o
- Address_o  output  DATA_WIDTH  current PC (byte address) to ROM
- IF_Instruction_o  output  DATA_WIDTH  registered instruction to decode
- IF_PC_Plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction
- IF_Valid_o  output  1  IF/ID register holds a real instruction
- Fault_o  output  1  sticky fetch fault
- Fault_Addr_o  output  DATA_WIDTH  offending address, captured at the fault

## Operation
- PC window: legal iff PC[1:0]==0 and TEXT_BASE <= PC < TEXT_BASE + 4*MEMORY_DEPTH; compare in DATA_WIDTH+1 bits so no wrap past 2^32.
- FSM states: BOOT, RUN, FAULT.
  - BOOT: entered on reset; fetch suppressed for one cycle (IF_Valid_o stays 0); then go to RUN unconditionally.
  - RUN: per-cycle priority: (1) Redirect_i; (2) Flush_i; (3) Stall_i; (4) sequential.
    - Redirect: illegal target -> FAULT, Fault_Addr_o <= target. Legal target -> PC <= target, IF/ID <= bubble. Stall is ignored.
    - Flush without redirect: PC <= PC+4, IF/ID <= bubble.
    - Stall: PC, IF/ID and IF_Valid_o hold.
    - Sequential: IF/ID <= {Instruction_i, PC+4}, IF_Valid_o <= 1, PC <= PC+4.
    - Sequential PC+4 that leaves the window: IF/ID still captures the current (last legal) instruction. The next cycle is in FAULT, with Fault_Addr_o = PC+4.
  - FAULT: PC frozen; IF/ID <= bubble each cycle; Fault_o = 1. Exited only by reset.
- Bubble = IF_Instruction_o 32'h0000_0000 (sll $0,$0,0), IF_PC_Plus4_o 0, IF_Valid_o 0.
- Address_o is always the PC register, never a combinational next-PC.

## Timing
- Reset (async assert, sync-released by clock): PC = TEXT_BASE, state BOOT. Outputs: Address_o = TEXT_BASE, IF_Instruction_o = 0, IF_PC_Plus4_o = 0, IF_Valid_o = 0, Fault_o = 0, Fault_Addr_o = 0.
- Reset asserted mid-operation: all of the above take effect immediately; no in-flight instruction survives.
- Fetch latency: instruction at Address_o during cycle n appears on IF_Instruction_o after edge n+1.
- First valid instruction (TEXT_BASE word) is on the IF/ID register two edges after reset release (BOOT + one fetch).
- Redirect penalty: one bubble cycle. The target instruction is valid two edges after the Redirect_i edge.
- Stall_i high for k cycles holds all outputs for exactly k cycles.
- Fault_o rises on the edge that enters FAULT; Address_o stays at its last legal value.

## Structure
- Shared package (pipeline_pkg): TEXT_BASE default, NOP_INSTR = 32'h0, fetch state enum {BOOT, RUN, FAULT}, IF/ID record typedef (instruction, pc_plus4, valid).
- One sub-module is natural: fetch_window_check. It is combinational, takes an address and returns legal, parameterised by TEXT_BASE/MEMORY_DEPTH. It is instantiated twice, once for the redirect target and once for PC+4.
- Top block holds the PC register, FSM and IF/ID register.

## Test plan
- Reset release, ROM model word k = 32'hA000_0000+k -> cycle 1 IF_Valid_o=0; cycle 2 IF_Instruction_o=A000_0000, IF_PC_Plus4_o=0040_0004; Address_o increments by 4 per cycle.
- Stall_i high 3 cycles at PC 0040_0008 -> Address_o, IF/ID outputs unchanged for 3 cycles; resumes with word 2 on release.
- Redirect_i with target 0040_0020 and Stall_i both high -> next cycle bubble (IF_Valid_o=0), Address_o=0040_0020; following cycle IF_Instruction_o=A000_0008.
- Redirect to 0040_0022 (misaligned) and separately to 0040_0100 (past 64 words) -> Fault_o=1, Fault_Addr_o=target, IF_Valid_o=0 every cycle until reset.
- Sequential run to 0040_00FC -> word 63 delivered valid; then Fault_o=1 with Fault_Addr_o=0040_0100.
- Reset asserted asynchronously while in RUN and in FAULT -> outputs return to reset values before the next clock edge; restart matches the first test.
